// File: rtl/rr_quantum_arbiter.sv
// Round-robin arbiter: 4 requesters share one resource, tenure capped at QUANTUM ready beats.
// Ports: clk, rst (async active-low), req, req_en, res_ready -> grant, grant_id, grant_valid, expired.
module rr_quantum_arbiter #(
  parameter int QUANTUM = 8,
  parameter int CW      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] req_en,
  input  logic       res_ready,
  output logic [3:0] grant,
  output logic [1:0] grant_id,
  output logic       grant_valid,
  output logic       expired
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t        state, state_n;
  logic [1:0]    owner, owner_n;
  logic [CW-1:0] cnt, cnt_n;

  logic [3:0] elig;
  logic [1:0] win;
  logic [1:0] idx;
  logic       found;
  logic       last_beat;
  logic       rel;
  logic       tend;
  logic       exp_n;

  assign elig = req & req_en;

  // owner doubles as last_owner: search from owner+1, owner checked last
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < 4; k++) begin
      idx = owner + 2'(k + 1);
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign last_beat = res_ready && (cnt == CW'(QUANTUM - 1));
  assign rel       = !req[owner];
  assign tend      = (state == GRANT) && (rel || last_beat);
  // a release in the same cycle as the last beat is not an expiry
  assign exp_n     = (state == GRANT) && !rel && last_beat;

  always_comb begin
    state_n = state;
    owner_n = owner;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (found) begin
          state_n = GRANT;
          owner_n = win;
          cnt_n   = '0;
        end
      end
      GRANT: begin
        if (tend) begin
          cnt_n = '0;
          if (found) begin
            owner_n = win;
          end else begin
            state_n = IDLE;
          end
        end else if (res_ready) begin
          cnt_n = cnt + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      owner       <= 2'd3;
      cnt         <= '0;
      grant       <= '0;
      grant_id    <= '0;
      grant_valid <= 1'b0;
      expired     <= 1'b0;
    end else begin
      state       <= state_n;
      owner       <= owner_n;
      cnt         <= cnt_n;
      grant       <= (state_n == GRANT) ? (4'b0001 << owner_n) : 4'b0000;
      grant_id    <= (state_n == GRANT) ? owner_n : 2'd0;
      grant_valid <= (state_n == GRANT);
      expired     <= exp_n;
    end
  end

endmodule

// File: tb/tb_rr_quantum_arbiter.sv
// Directed bench for rr_quantum_arbiter (QUANTUM=8).
// Checks reset, rotation, ready-only quantum, release, masking, async reset.
module tb_rr_quantum_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] req_en;
  logic       res_ready;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic       grant_valid;
  logic       expired;

  int n_tests = 0;
  int n_fail  = 0;

  rr_quantum_arbiter #(.QUANTUM(8), .CW(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_en     (req_en),
    .res_ready  (res_ready),
    .grant      (grant),
    .grant_id   (grant_id),
    .grant_valid(grant_valid),
    .expired    (expired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  logic [3:0] rot [5];

  initial begin
    rot[0] = 4'b0001;
    rot[1] = 4'b0010;
    rot[2] = 4'b0100;
    rot[3] = 4'b1000;
    rot[4] = 4'b0001;

    rst       = 1'b0;
    req       = 4'b0000;
    req_en    = 4'b1111;
    res_ready = 1'b0;

    // reset state
    #2;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_id", 32'(grant_id), 32'h0);
    chk("rst_valid", 32'(grant_valid), 32'h0);
    chk("rst_exp", 32'(expired), 32'h0);
    step();
    rst = 1'b1;
    step();
    chk("idle_grant", 32'(grant), 32'h0);
    chk("idle_valid", 32'(grant_valid), 32'h0);
    req = 4'b1010;
    step();
    chk("first_grant", 32'(grant), 32'b0010);
    chk("first_id", 32'(grant_id), 32'd1);
    chk("first_valid", 32'(grant_valid), 32'h1);
    req = 4'b0000;
    step();
    chk("release_idle", 32'(grant), 32'h0);

    // rotation, 8 beats per tenure
    do_reset();
    req       = 4'b1111;
    res_ready = 1'b1;
    step();
    for (int g = 0; g < 5; g++) begin
      for (int c = 0; c < 8; c++) begin
        chk($sformatf("rot_g%0d_c%0d", g, c), 32'(grant), 32'(rot[g]));
        chk($sformatf("rot_e%0d_c%0d", g, c), 32'(expired),
            32'((c == 0 && g > 0) ? 1 : 0));
        step();
      end
    end
    chk("rot_wrap_id", 32'(grant_id), 32'd1);

    // only ready beats consume quantum
    do_reset();
    req = 4'b0100;
    res_ready = 1'b0;
    step();
    for (int t = 0; t < 2; t++) begin
      for (int c = 0; c < 16; c++) begin
        chk($sformatf("rdy_g%0d_c%0d", t, c), 32'(grant), 32'b0100);
        chk($sformatf("rdy_e%0d_c%0d", t, c), 32'(expired),
            32'((c == 0 && t > 0) ? 1 : 0));
        res_ready = (c % 2) == 1;
        step();
      end
    end
    chk("rdy_end_grant", 32'(grant), 32'b0100);
    chk("rdy_end_exp", 32'(expired), 32'h1);

    // early release, then release coinciding with last beat
    do_reset();
    req       = 4'b1001;
    res_ready = 1'b1;
    step();
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("early_own_c%0d", c), 32'(grant), 32'b0001);
      step();
    end
    req = 4'b1000;
    step();
    chk("early_grant", 32'(grant), 32'b1000);
    chk("early_id", 32'(grant_id), 32'd3);
    chk("early_exp", 32'(expired), 32'h0);
    for (int c = 0; c < 7; c++) step();
    chk("tie_hold", 32'(grant), 32'b1000);
    req = 4'b0001;
    step();
    chk("tie_grant", 32'(grant), 32'b0001);
    chk("tie_exp", 32'(expired), 32'h0);

    // masking and mid-tenure enable clear
    do_reset();
    req       = 4'b0011;
    req_en    = 4'b0010;
    res_ready = 1'b1;
    step();
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("mask_a_c%0d", c), 32'(grant), 32'b0010);
      if (c < 3) step();
    end
    req_en = 4'b0000;
    for (int c = 0; c < 4; c++) begin
      step();
      chk($sformatf("mask_b_c%0d", c), 32'(grant), 32'b0010);
    end
    step();
    chk("mask_idle", 32'(grant), 32'h0);
    chk("mask_valid", 32'(grant_valid), 32'h0);
    chk("mask_exp", 32'(expired), 32'h1);
    step();
    chk("mask_idle2", 32'(grant), 32'h0);
    chk("mask_exp2", 32'(expired), 32'h0);

    // asynchronous reset mid-tenure
    req_en = 4'b1111;
    do_reset();
    req = 4'b0100;
    step();
    chk("ar_pre", 32'(grant), 32'b0100);
    rst = 1'b0;
    #1;
    chk("ar_grant", 32'(grant), 32'h0);
    chk("ar_valid", 32'(grant_valid), 32'h0);
    req = 4'b1100;
    step();
    chk("ar_held", 32'(grant), 32'h0);
    rst = 1'b1;
    step();
    chk("ar_after", 32'(grant), 32'b0100);
    chk("ar_id", 32'(grant_id), 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_quantum_arbiter.md
Name: rr_quantum_arbiter

Overview:
- Shares one resource (e.g. a bus or memory port) among 4 requesters using round-robin order with a bounded tenure per grant.
- A granted requester keeps the resource until it drops its request, or until it has used QUANTUM accepted cycles.
- Grant hands over directly to the next eligible requester with no idle bubble.
- Sits between the requester front-ends and the shared resource mux. Per-requester enables come from a configuration register.

Parameters:
- QUANTUM, 8: maximum resource-accepted cycles per tenure. Legal range 1..15.
- CW, 4: width of the tenure counter. Must satisfy 2^CW > QUANTUM.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- req  input  4  request per requester; held high while requester wants the resource.
- req_en  input  4  configuration mask; a requester with req_en[i]=0 is never newly granted.
- res_ready  input  1  resource accepted a beat this cycle; only these cycles consume quantum.
- grant  output  4  registered one-hot grant, or all zero.
- grant_id  output  2  binary index of the current owner; 0 when no grant.
- grant_valid  output  1  high when grant is nonzero.
- expired  output  1  one-cycle registered pulse when a tenure ended by quantum exhaustion.

Behaviour:
- Reset (rst=0, asynchronous): grant=0, grant_id=0, grant_valid=0, expired=0, state=IDLE, tenure count=0, last_owner=3. The first arbitration after reset therefore searches from requester 0.
- Eligible set: E = req & req_en.
- Round-robin pick: search starts at last_owner+1 (mod 4), wraps, and checks last_owner last.
- State machine has two states.
- IDLE:
  - If E != 0, the winner is granted at the next edge: state GRANT, count=0, last_owner=winner.
  - Otherwise remain IDLE.
  - Latency from req rise to grant high is 1 cycle.
- GRANT: the owner is o.
  - Tenure-ends condition: req[o]=0, or (res_ready=1 and count==QUANTUM-1).
  - While the tenure continues, count increments on each res_ready=1 cycle and holds otherwise.
  - When the tenure ends, re-pick from E at the same edge, starting search from o+1:
    - If a winner exists, grant moves to it at the next edge and count is cleared.
    - If no winner exists, go to IDLE with grant=0.
  - The old owner remains a candidate, so a sole requester whose quantum expired is re-granted immediately with count=0. expired still pulses.
- Clearing req_en[o] while o is granted does not revoke the grant. It takes effect at the next arbitration.
- req[o] falling and quantum expiring in the same cycle: treated as a release. expired=0.
- expired=1 for exactly the cycle after a quantum-exhaustion handover. Otherwise it is 0.
- Outputs are driven from registers only; there is no combinational path from req to grant.
- Reset asserted mid-tenure clears everything immediately, without waiting for a clock. After reset is released, arbitration restarts from requester 0.
- count never exceeds QUANTUM-1.

Test Plan:
- Reset behaviour: hold rst=0, then release with req=4'b0000 → grant=0 and grant_valid=0. Then set req=4'b1010, req_en=4'b1111 → one cycle later grant=4'b0010 and grant_id=1.
- Round-robin rotation: req=4'b1111, res_ready=1, QUANTUM=8 → grant sequence 0001, 0010, 0100, 1000, 0001, with each tenure exactly 8 cycles and expired pulsing once per handover.
- Quantum counts only ready cycles: single requester req=4'b0100 with res_ready toggling 1/0 → tenure lasts 16 cycles. grant stays 0100 throughout, count resets, and expired pulses each 16 cycles.
- Early release: owner 0 drops req after 3 cycles while req[3]=1 → grant=1000 at the next edge, no idle cycle, expired=0.
- Masking: req=4'b0011, req_en=4'b0010 → only 0010 is ever granted. Clear req_en[1] mid-tenure → grant holds until req[1] drops or the quantum expires, then goes to IDLE.
- Reset mid-operation: assert rst during a grant of 0100 → grant=0 immediately (asynchronous). After release with req=4'b1100 → grant=0100.
